// File: rtl/sram_arbiter_if.sv
// Requester-side bundle for sram_arbiter: three packed request ports plus shared
// grant/read-return signals. Port i occupies slice i of every packed vector.
interface sram_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic [2:0]          req;
  logic [2:0]          req_we;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_wdata;
  logic [5:0]          req_be;
  logic                lock0;
  logic [2:0]          gnt;
  logic [2:0]          rvalid;
  logic [DATA_W-1:0]   rdata;

  modport master (
    output req, req_we, req_addr, req_wdata, req_be, lock0,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, req_be, lock0,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Three-port arbiter owning an external async SRAM: pipelined single-cycle reads,
// three-cycle setup/pulse/hold writes, port 0 on top with a bounded run, ports 1/2 round-robin.
module sram_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int P0_MAX_RUN = 64
) (
  input  logic              clk,
  input  logic              reset,
  sram_arbiter_if.slave     bus,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_din,
  output logic [DATA_W-1:0] ram_dout,
  output logic              ram_ce,
  output logic              ram_oe,
  output logic              ram_we,
  output logic              ram_lb,
  output logic              ram_hb
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } stateType;

  // One spare bit so the saturating counter can always sit at or above the limit.
  localparam int              RUN_W     = $clog2(P0_MAX_RUN + 2);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(P0_MAX_RUN);

  stateType          state;
  logic [RUN_W-1:0]  runCount;
  logic              rrPtr;      // 0: port 1 preferred next, 1: port 2 preferred next
  logic [1:0]        curPort;

  logic              runLimited;
  logic              winValid;
  logic [1:0]        winPort;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;
  logic [1:0]        selBe;

  function automatic logic [2:0] portOneHot(input logic [1:0] p);
    case (p)
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  assign runLimited = (P0_MAX_RUN != 0) && (runCount >= RUN_LIMIT) &&
                      (bus.req[1] | bus.req[2]) && !bus.lock0;

  assign busy = (state != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
    winValid = 1'b0;
    winPort  = 2'd0;
    if (bus.req[0] && !runLimited) begin
      winValid = 1'b1;
      winPort  = 2'd0;
    end else if (!bus.lock0 && (bus.req[1] | bus.req[2])) begin
      winValid = 1'b1;
      if (!rrPtr) winPort = bus.req[1] ? 2'd1 : 2'd2;
      else        winPort = bus.req[2] ? 2'd2 : 2'd1;
    end
  end

  always_comb begin
    selWe   = 1'b0;
    selAddr = '0;
    selData = '0;
    selBe   = 2'b00;
    case (winPort)
      2'd1: begin
        selWe   = bus.req_we[1];
        selAddr = bus.req_addr[ADDR_W +: ADDR_W];
        selData = bus.req_wdata[DATA_W +: DATA_W];
        selBe   = bus.req_be[3:2];
      end
      2'd2: begin
        selWe   = bus.req_we[2];
        selAddr = bus.req_addr[2*ADDR_W +: ADDR_W];
        selData = bus.req_wdata[2*DATA_W +: DATA_W];
        selBe   = bus.req_be[5:4];
      end
      default: begin
        selWe   = bus.req_we[0];
        selAddr = bus.req_addr[0 +: ADDR_W];
        selData = bus.req_wdata[0 +: DATA_W];
        selBe   = bus.req_be[1:0];
      end
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      runCount   <= '0;
      rrPtr      <= 1'b0;
      curPort    <= 2'd0;
      bus.gnt    <= 3'b000;
      bus.rvalid <= 3'b000;
      bus.rdata  <= '0;
      ram_addr   <= '0;
      ram_dout   <= '0;
      ram_ce     <= 1'b0;
      ram_oe     <= 1'b0;
      ram_we     <= 1'b0;
      ram_lb     <= 1'b1;
      ram_hb     <= 1'b1;
    end else begin
      bus.gnt    <= 3'b000;
      bus.rvalid <= 3'b000;

      if (state == READ) begin
        bus.rdata  <= ram_din;
        bus.rvalid <= portOneHot(curPort);
      end

      case (state)
        WR_SETUP: begin
          ram_we <= 1'b1;
          state  <= WR_PULSE;
        end
        WR_PULSE: begin
          ram_we <= 1'b0;
          state  <= WR_HOLD;
        end
        default: begin
          if (winValid) begin
            bus.gnt  <= portOneHot(winPort);
            curPort  <= winPort;
            ram_addr <= selAddr;
            ram_ce   <= 1'b1;
            ram_we   <= 1'b0;
            if (selWe) begin
              ram_dout <= selData;
              ram_oe   <= 1'b0;
              ram_hb   <= selBe[1];
              ram_lb   <= selBe[0];
              state    <= WR_SETUP;
            end else begin
              ram_oe   <= 1'b1;
              ram_hb   <= 1'b1;
              ram_lb   <= 1'b1;
              state    <= READ;
            end
            if (winPort == 2'd0) begin
              if (runCount != '1) runCount <= runCount + 1'b1;
            end else begin
              runCount <= '0;
              rrPtr    <= (winPort == 2'd1);
            end
          end else begin
            state  <= IDLE;
            ram_ce <= 1'b0;
            ram_oe <= 1'b0;
            ram_we <= 1'b0;
            ram_lb <= 1'b1;
            ram_hb <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
